// File: rtl/edge2en_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge2en_pkg                                                          |
// | Shared edge-select encoding and helpers for multi_edge2en.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package edge2en_pkg;

  // Per-channel edge selection carried on two bits of the mode bus
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_e;

  // Legal channel count range
  localparam int CH_MIN = 1;
  localparam int CH_MAX = 32;

  // Select which detected edges produce an enable for a given mode
  function automatic logic edge_sel(input edge_mode_e m, input logic rise, input logic fall);
    logic take_rise;
    logic take_fall;
    take_rise = (m == EDGE_RISE) || (m == EDGE_BOTH);
    take_fall = (m == EDGE_FALL) || (m == EDGE_BOTH);
    return (rise & take_rise) | (fall & take_fall);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge2en_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge2en_chan                                                         |
// | One channel: synchroniser, debounce filter, edge detect and sticky   |
// | pending/overrun flags.                                               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module edge2en_chan
  import edge2en_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  edge_mode_e mode,
  input  logic       clr,
  output logic       level,
  output logic       en,
  output logic       pending,
  output logic       overrun
);

  logic s;

  if (SYNC_STAGES == 0) begin : g_nosync
    // Input already synchronous to clk: use it directly
    assign s = in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw input one stage further down the chain each cycle
    always_comb begin
      sync_d    = sync_q;
      sync_d[0] = in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    // Synchroniser flops
    always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  if (FILT_LEN == 0) begin : g_nofilt
    // Filter bypassed: level follows the synchronised input
    assign level = s;
  end else begin : g_filt
    localparam int CNT_W = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // Count consecutive disagreeing samples; flip level on the FILT_LEN-th
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (s != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = ~level_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Debounce state
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign level = level_q;
  end

  logic prev_q;
  logic prev_d;
  logic pending_q;
  logic pending_d;
  logic overrun_q;
  logic overrun_d;
  logic rise;
  logic fall;

  // Edge detect, mode gating and next state of the sticky flags.
  // en is masked while rst is high so a combinational path from in
  // cannot pulse during reset; the flags let a new edge win over clr.
  always_comb begin
    prev_d    = level;
    rise      = level & ~prev_q;
    fall      = ~level & prev_q;
    en        = ~rst & edge_sel(mode, rise, fall);
    pending_d = en | (pending_q & ~clr);
    overrun_d = (en & pending_q) | (overrun_q & ~clr);
  end

  // Previous level and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: rtl/multi_edge2en.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_edge2en                                                        |
// | CH independent level-to-enable converters with optional             |
// | synchroniser, debounce and sticky pending/overrun status.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module multi_edge2en
  import edge2en_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   en,
  output logic [CH-1:0]   pending,
  output logic [CH-1:0]   overrun,
  output logic            any_en
);

  if ((CH < CH_MIN) || (CH > CH_MAX)) begin : g_bad_ch
    $error("multi_edge2en: CH=%0d outside 1..32", CH);
  end

  if ((SYNC_STAGES < 0) || (FILT_LEN < 0)) begin : g_bad_param
    $error("multi_edge2en: SYNC_STAGES and FILT_LEN must be non-negative");
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge2en_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .in      (in[i]),
      .mode    (edge_mode_e'(mode[2*i +: 2])),
      .clr     (clr[i]),
      .level   (level[i]),
      .en      (en[i]),
      .pending (pending[i]),
      .overrun (overrun[i])
    );
  end

  assign any_en = |en;

endmodule
`default_nettype wire

// File: tb/tb_multi_edge2en.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_edge2en                                                     |
// | Scoreboard bench: stimulus pushes expected enable pulses, a negedge  |
// | monitor pops them as the DUTs raise en.                              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_multi_edge2en;
  import edge2en_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done = 1'b0;

  // DUT A: CH=4, SYNC_STAGES=2, FILT_LEN=3 (in -> en latency 4 edges after sampling edge)
  logic [3:0] a_in = '0;
  logic [7:0] a_mode = '0;
  logic [3:0] a_clr = '0;
  logic [3:0] a_level, a_en, a_pending, a_overrun;
  logic       a_any_en;

  // DUT B: CH=2, no synchroniser, no filter
  logic [1:0] b_in = '0;
  logic [3:0] b_mode = '0;
  logic [1:0] b_clr = '0;
  logic [1:0] b_level, b_en, b_pending, b_overrun;
  logic       b_any_en;

  typedef struct {
    int dut;
    int ch;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  multi_edge2en #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(3)) u_dut_a (
    .clk(clk), .rst(rst), .in(a_in), .mode(a_mode), .clr(a_clr),
    .level(a_level), .en(a_en), .pending(a_pending), .overrun(a_overrun),
    .any_en(a_any_en)
  );

  multi_edge2en #(.CH(2), .SYNC_STAGES(0), .FILT_LEN(0)) u_dut_b (
    .clk(clk), .rst(rst), .in(b_in), .mode(b_mode), .clr(b_clr),
    .level(b_level), .en(b_en), .pending(b_pending), .overrun(b_overrun),
    .any_en(b_any_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int d, input int c, input int at);
    ev_t e;
    e.dut = d;
    e.ch  = c;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(input int d, input int c);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_en: dut %0d ch %0d at cyc %0d, none expected", d, c, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.ch != c || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL en_pulse: got dut %0d ch %0d cyc %0d expected dut %0d ch %0d cyc %0d",
                 d, c, cyc, e.dut, e.ch, e.cyc);
      end
    end
  endtask

  // Wait until the given edge has occurred, then step 2 time units past it
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: every enable pulse seen must match the head of the expected queue
  always @(negedge clk) begin
    if (!done) begin
      for (int c = 0; c < 4; c++) if (a_en[c] === 1'b1) mon_ev(0, c);
      for (int c = 0; c < 2; c++) if (b_en[c] === 1'b1) mon_ev(1, c);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ch3 RISE, ch2 RISE, ch1 BOTH, ch0 RISE
    a_mode = {EDGE_RISE, EDGE_RISE, EDGE_BOTH, EDGE_RISE};
    b_mode = {EDGE_OFF, EDGE_RISE};

    wait_until(3);
    check("reset_level", 32'(a_level), 32'h0);
    check("reset_pending", 32'(a_pending), 32'h0);
    check("reset_overrun", 32'(a_overrun), 32'h0);
    check("reset_any_en", 32'(a_any_en), 32'h0);
    rst = 1'b0;

    // Zero-latency path: en follows the input rise within the same cycle
    wait_until(5);
    b_in = 2'b11;
    push_ev(1, 0, 5);
    #1;
    check("b_level_comb", 32'(b_level), 32'h3);
    check("b_en_comb", 32'(b_en), 32'h1);
    check("b_any_en_comb", 32'(b_any_en), 32'h1);
    wait_until(6);
    check("b_en_one_cycle", 32'(b_en), 32'h0);
    wait_until(7);
    b_in = 2'b00;

    // ch0 clean rise sampled at edge 10; ch1 two-cycle glitch
    wait_until(9);
    a_in[0] = 1'b1;
    a_in[1] = 1'b1;
    push_ev(0, 0, 14);
    wait_until(11);
    a_in[1] = 1'b0;
    wait_until(13);
    check("ch0_level_before", 32'(a_level[0]), 32'h0);
    wait_until(14);
    check("ch0_level_after", 32'(a_level[0]), 32'h1);
    check("ch0_pending_en_cycle", 32'(a_pending[0]), 32'h0);
    wait_until(15);
    check("ch0_pending_set", 32'(a_pending[0]), 32'h1);
    check("ch0_overrun_clear", 32'(a_overrun[0]), 32'h0);

    // ch2: first accepted rise
    wait_until(16);
    check("ch1_glitch_level", 32'(a_level[1]), 32'h0);
    check("ch1_glitch_pending", 32'(a_pending[1]), 32'h0);
    a_in[2] = 1'b1;
    push_ev(0, 2, 21);
    wait_until(22);
    a_in[2] = 1'b0;
    // second rise while pending -> overrun
    wait_until(28);
    a_in[2] = 1'b1;
    push_ev(0, 2, 33);
    wait_until(34);
    check("ch2_pending_2nd", 32'(a_pending[2]), 32'h1);
    check("ch2_overrun_2nd", 32'(a_overrun[2]), 32'h1);
    wait_until(35);
    a_in[2] = 1'b0;
    // third rise with clr in the same cycle: set wins
    wait_until(41);
    a_in[2] = 1'b1;
    push_ev(0, 2, 46);
    wait_until(46);
    a_clr[2] = 1'b1;
    wait_until(47);
    check("ch2_pending_set_wins", 32'(a_pending[2]), 32'h1);
    check("ch2_overrun_set_wins", 32'(a_overrun[2]), 32'h1);
    wait_until(48);
    a_clr[2] = 1'b0;
    check("ch2_pending_cleared", 32'(a_pending[2]), 32'h0);
    check("ch2_overrun_cleared", 32'(a_overrun[2]), 32'h0);

    // ch0 falling edge in FALL mode
    a_mode[1:0] = EDGE_FALL;
    wait_until(50);
    a_in[0] = 1'b0;
    push_ev(0, 0, 55);
    wait_until(55);
    check("ch0_fall_any_en", 32'(a_any_en), 32'h1);
    wait_until(56);
    check("ch0_fall_any_en_drop", 32'(a_any_en), 32'h0);
    check("ch0_overrun_fall", 32'(a_overrun[0]), 32'h1);
    // OFF mode: level moves, no pulse
    a_mode[1:0] = EDGE_OFF;
    wait_until(57);
    a_in[0] = 1'b1;
    wait_until(62);
    check("ch0_off_level", 32'(a_level[0]), 32'h1);

    // Input held high across reset is reported as a rise after release
    wait_until(64);
    rst = 1'b1;
    a_in[3] = 1'b1;
    wait_until(69);
    check("rst2_level", 32'(a_level), 32'h0);
    check("rst2_pending", 32'(a_pending), 32'h0);
    check("rst2_overrun", 32'(a_overrun), 32'h0);
    rst = 1'b0;
    push_ev(0, 2, 74);
    push_ev(0, 3, 74);
    wait_until(74);
    check("rst2_level_rise", 32'(a_level), 32'hD);
    wait_until(75);
    check("rst2_pending_rise", 32'(a_pending), 32'hC);

    // Reset in the middle of a debounce discards it
    wait_until(80);
    a_in[3] = 1'b0;
    wait_until(84);
    rst = 1'b1;
    a_in = 4'b0000;
    wait_until(86);
    rst = 1'b0;
    wait_until(95);
    check("rst3_level", 32'(a_level), 32'h0);
    check("rst3_pending", 32'(a_pending), 32'h0);

    wait_until(100);
    done = 1'b1;
    check("expected_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
